// File: rtl/axil_mem_pkg.sv
// axil_mem_pkg: shared types for the AXI4-Lite register/memory bank.
//   resp_e    : AXI response encodings
//   wstate_e  : write-channel FSM states
//   rstate_e  : read-channel FSM states
//   region_e  : address decode result
//   region_of : classifies a byte address into register / memory / unmapped
package axil_mem_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_REG,
        REGION_MEM
    } region_e;

    // All window bounds are multiples of the word size, so comparing the raw
    // byte address gives the same answer as comparing its word-aligned form.
    function automatic region_e region_of(input logic [63:0] addr,
                                          input logic [63:0] reg_bytes,
                                          input logic [63:0] mem_base,
                                          input logic [63:0] mem_bytes);
        region_e r;
        r = REGION_NONE;
        if (addr < reg_bytes)
            r = REGION_REG;
        else if (addr >= mem_base && addr < mem_base + mem_bytes)
            r = REGION_MEM;
        return r;
    endfunction

endpackage

// File: rtl/axil_mem_ram.sv
// axil_mem_ram: simple dual-port RAM, one byte-enabled write port and one
// synchronous read port, written for block-RAM inference.
//   i_clk   : clock
//   i_we    : per-byte write enables
//   i_waddr : write word address
//   i_wdata : write data
//   i_re    : read enable; o_rdata only changes when this is high
//   i_raddr : read word address
//   o_rdata : registered read data (old data on a same-address collision)
module axil_mem_ram #(
    parameter int  DATA_W    = 32,
    parameter int  MEM_DEPTH = 256,
    localparam int STRB_W    = DATA_W / 8,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic [STRB_W-1:0] i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (i_we[b])
                r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_mem_bank.sv
// axil_mem_bank: AXI4-Lite slave exposing NREG control registers at offset 0
// and a MEM_DEPTH-word memory window at MEM_BASE. Unmapped accesses get
// DECERR (writes dropped, reads return 0).
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*      : write address / data, accepted independently
//   S_AXI_B*                  : write response, held until BREADY
//   S_AXI_AR* / S_AXI_R*      : read address / data, held until RREADY
module axil_mem_bank
    import axil_mem_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          NREG      = 8,
    parameter int unsigned MEM_BASE  = 32'h400,
    parameter int          MEM_DEPTH = 256,
    localparam int         STRB_W    = DATA_W / 8
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [DATA_W-1:0] S_AXI_WDATA,
    input  logic [STRB_W-1:0] S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [DATA_W-1:0] S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);

    localparam int          BYTE_OFF  = $clog2(STRB_W);
    localparam int          MAW       = $clog2(MEM_DEPTH);
    localparam int          RIW       = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [63:0] REG_BYTES = 64'(NREG) * 64'(STRB_W);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(STRB_W);
    localparam logic [63:0] MEM_BASE64 = 64'(MEM_BASE);

    wstate_e           r_wstate, w_wstate_nxt;
    rstate_e           r_rstate, w_rstate_nxt;
    logic [ADDR_W-1:0] r_awaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [1:0]        r_bresp, r_rresp;
    logic              r_rsel_mem;
    logic [DATA_W-1:0] r_reg_rdata;
    logic [DATA_W-1:0] r_regs [NREG];

    logic              w_awready, w_wready, w_arready;
    logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    region_e           w_wregion, w_rregion;
    logic [RIW-1:0]    w_wreg_idx, w_rreg_idx;
    logic [STRB_W-1:0] w_ram_we;
    logic [DATA_W-1:0] w_ram_q;

    // The completing half of a write comes straight from the bus; the half
    // that arrived earlier comes from its capture register.
    assign w_waddr    = (r_wstate == W_HAVE_AW) ? r_awaddr : S_AXI_AWADDR;
    assign w_wdata    = (r_wstate == W_HAVE_W)  ? r_wdata  : S_AXI_WDATA;
    assign w_wstrb    = (r_wstate == W_HAVE_W)  ? r_wstrb  : S_AXI_WSTRB;
    assign w_wregion  = region_of(64'(w_waddr), REG_BYTES, MEM_BASE64, MEM_BYTES);
    assign w_rregion  = region_of(64'(S_AXI_ARADDR), REG_BYTES, MEM_BASE64, MEM_BYTES);
    assign w_wreg_idx = w_waddr[BYTE_OFF +: RIW];
    assign w_rreg_idx = S_AXI_ARADDR[BYTE_OFF +: RIW];

    // ---------------- write channel ----------------
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        case (r_wstate)
            W_IDLE:    begin w_awready = 1'b1; w_wready = 1'b1; end
            W_HAVE_AW: w_wready  = 1'b1;
            W_HAVE_W:  w_awready = 1'b1;
            default:   ;
        endcase
        if (S_AXI_ARESET) begin
            w_awready = 1'b0;
            w_wready  = 1'b0;
        end
        w_aw_hs  = S_AXI_AWVALID & w_awready;
        w_w_hs   = S_AXI_WVALID & w_wready;
        w_commit = (w_aw_hs | (r_wstate == W_HAVE_AW)) & (w_w_hs | (r_wstate == W_HAVE_W));
        if (w_commit)
            w_wstate_nxt = W_RESP;
        else if (w_aw_hs)
            w_wstate_nxt = W_HAVE_AW;
        else if (w_w_hs)
            w_wstate_nxt = W_HAVE_W;
        else if (r_wstate == W_RESP && S_AXI_BREADY)
            w_wstate_nxt = W_IDLE;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs)
                r_awaddr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit)
                r_bresp <= (w_wregion == REGION_NONE) ? RESP_DECERR : RESP_OKAY;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_commit && w_wregion == REGION_REG) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_wstrb[b])
                    r_regs[w_wreg_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    assign w_ram_we = (w_commit && w_wregion == REGION_MEM) ? w_wstrb : '0;

    // ---------------- read channel ----------------
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = (r_rstate == R_IDLE) & ~S_AXI_ARESET;
        w_ar_hs      = S_AXI_ARVALID & w_arready;
        if (w_ar_hs)
            w_rstate_nxt = R_DATA;
        else if (r_rstate == R_DATA && S_AXI_RREADY)
            w_rstate_nxt = R_IDLE;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate    <= R_IDLE;
            r_rresp     <= RESP_OKAY;
            r_rsel_mem  <= 1'b0;
            r_reg_rdata <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_rresp     <= (w_rregion == REGION_NONE) ? RESP_DECERR : RESP_OKAY;
                r_rsel_mem  <= (w_rregion == REGION_MEM);
                r_reg_rdata <= (w_rregion == REGION_REG) ? r_regs[w_rreg_idx] : '0;
            end
        end
    end

    // RAM output only moves on a memory AR handshake, so it stays stable
    // while RVALID waits for RREADY, even if that word is rewritten meanwhile.
    axil_mem_ram #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .i_clk   (S_AXI_ACLK),
        .i_we    (w_ram_we),
        .i_waddr (w_waddr[BYTE_OFF +: MAW]),
        .i_wdata (w_wdata),
        .i_re    (w_ar_hs && w_rregion == REGION_MEM),
        .i_raddr (S_AXI_ARADDR[BYTE_OFF +: MAW]),
        .o_rdata (w_ram_q)
    );

    assign S_AXI_AWREADY = w_awready;
    assign S_AXI_WREADY  = w_wready;
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_arready;
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rsel_mem ? w_ram_q : r_reg_rdata;

endmodule

// File: tb/tb_axil_mem_bank.sv
// Bench for axil_mem_bank: directed steps plus randomized traffic, checked
// against an address-map model (register array + memory array).
module tb_axil_mem_bank;

    logic        clk, rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [8];
    logic [31:0] m_mem [256];

    axil_mem_bank dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---- reference model: address map from the block's documented windows ----
    // regs: bytes 0x000..0x01F, memory: bytes 0x400..0x7FF, everything else unmapped
    function automatic int m_region(input logic [31:0] a);
        if (a < 32'h20) return 1;
        if (a >= 32'h400 && a < 32'h800) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return (m_region(a) == 0) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        case (m_region(a))
            1:       return m_reg[a / 4];
            2:       return m_mem[(a - 32'h400) / 4];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        case (m_region(a))
            1: m_reg[a / 4] = merge(m_reg[a / 4], d, s);
            2: m_mem[(a - 32'h400) / 4] = merge(m_mem[(a - 32'h400) / 4], d, s);
            default: ;
        endcase
    endtask

    // mode 0: AW+W together, 1: W then AW, 2: AW then W; bp = cycles BREADY held low
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input int bp);
        logic [1:0] er;
        er = m_resp(a);
        chk("aw_idle", awready, 1);
        chk("w_idle", wready, 1);
        case (mode)
            0: begin
                awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
                tick;
                awvalid = 0; wvalid = 0;
            end
            1: begin
                wdata = d; wstrb = s; wvalid = 1;
                tick;
                wvalid = 0; wdata = $urandom; wstrb = 4'($urandom);
                chk("have_w_awrdy", awready, 1);
                chk("have_w_wrdy", wready, 0);
                chk("have_w_bvalid", bvalid, 0);
                awaddr = a; awvalid = 1;
                tick;
                awvalid = 0;
            end
            default: begin
                awaddr = a; awvalid = 1;
                tick;
                awvalid = 0; awaddr = $urandom;
                chk("have_aw_awrdy", awready, 0);
                chk("have_aw_wrdy", wready, 1);
                chk("have_aw_bvalid", bvalid, 0);
                wdata = d; wstrb = s; wvalid = 1;
                tick;
                wvalid = 0;
            end
        endcase
        m_write(a, d, s);
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, er);
        chk("resp_awrdy", awready, 0);
        chk("resp_wrdy", wready, 0);
        for (int i = 0; i < bp; i++) begin
            tick;
            chk("bp_bvalid", bvalid, 1);
            chk("bp_bresp", bresp, er);
            chk("bp_awrdy", awready, 0);
            chk("bp_wrdy", wready, 0);
        end
        bready = 1;
        tick;
        bready = 0;
        chk("b_done", bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int bp, output logic [31:0] got);
        logic [31:0] ed;
        logic [1:0]  er;
        ed = m_rdata(a);
        er = m_resp(a);
        chk("ar_idle", arready, 1);
        araddr = a; arvalid = 1;
        tick;
        arvalid = 0; araddr = $urandom;
        chk("rvalid", rvalid, 1);
        chk("r_arrdy", arready, 0);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        got = rdata;
        for (int i = 0; i < bp; i++) begin
            tick;
            chk("bp_rvalid", rvalid, 1);
            chk("bp_rdata", rdata, ed);
            chk("bp_rresp", rresp, er);
            chk("bp_arrdy", arready, 0);
        end
        rready = 1;
        tick;
        rready = 0;
        chk("r_done", rvalid, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 31));
            1, 2:    return 32'h400 + 32'($urandom_range(0, 1023));
            3:       return 32'($urandom_range(32'h20, 32'h3FF));
            default: return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(32'h800, 32'hFFFF))
                                                        : 32'hFFFF_F400 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [31:0] got, old;
        rst = 1; awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;

        // reset state
        tick; tick;
        chk("rst_awrdy", awready, 0);
        chk("rst_wrdy", wready, 0);
        chk("rst_arrdy", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        rst = 0;
        tick;
        chk("post_rst_awrdy", awready, 1);
        chk("post_rst_wrdy", wready, 1);
        chk("post_rst_arrdy", arready, 1);

        for (int i = 0; i < 8; i++) axi_read(32'(i * 4), 0, got);

        // give the whole memory window known contents
        for (int i = 0; i < 256; i++)
            axi_write(32'h400 + 32'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), 0);

        // W before AW into a register
        axi_write(32'h10, 32'hABAD1DEA, 4'hF, 1, 0);
        axi_read(32'h10, 0, got);
        chk("reg4_const", got, 32'hABAD1DEA);

        // AW and W together into memory; neighbour unaffected
        axi_write(32'h400, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read(32'h400, 0, got);
        chk("mem0_const", got, 32'hDEADBEEF);
        axi_read(32'h404, 0, got);

        // byte strobes, and an all-zero strobe no-op
        axi_write(32'h408, 32'hFFFFFFFF, 4'hF, 2, 0);
        axi_write(32'h408, 32'h11223344, 4'b0101, 0, 0);
        axi_read(32'h408, 0, got);
        chk("strobe_const", got, 32'hFF22FF44);
        axi_write(32'h408, 32'h0, 4'b0000, 1, 0);
        axi_read(32'h408, 0, got);

        // unmapped addresses
        axi_write(32'h200, 32'h12345678, 4'hF, 0, 0);
        axi_write(32'h800, 32'h87654321, 4'hF, 2, 0);
        axi_read(32'h200, 0, got);
        axi_read(32'h800, 0, got);
        chk("decerr_rdata", got, 0);
        axi_read(32'h10, 0, got);
        axi_read(32'h7FC, 0, got);

        // back-pressure on both response channels
        axi_write(32'h40C, 32'hC0FFEE00, 4'hF, 0, 5);
        axi_read(32'h40C, 5, got);
        axi_read(32'h14, 5, got);

        // write commit and read accept to the same word in one cycle
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            a = (k == 0) ? 32'h410 : 32'h0C;
            old = m_rdata(a);
            awaddr = a; awvalid = 1; wdata = 32'h5A5A0F0F + 32'(k); wstrb = 4'hF; wvalid = 1;
            araddr = a; arvalid = 1;
            tick;
            awvalid = 0; wvalid = 0; arvalid = 0;
            chk("coll_bvalid", bvalid, 1);
            chk("coll_rvalid", rvalid, 1);
            chk("coll_rdata_old", rdata, old);
            m_write(a, 32'h5A5A0F0F + 32'(k), 4'hF);
            bready = 1; rready = 1;
            tick;
            bready = 0; rready = 0;
            axi_read(a, 0, got);
        end

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 1)
                axi_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2),
                          $urandom_range(0, 2));
            else
                axi_read(rand_addr(), $urandom_range(0, 2), got);
        end

        // reset in the middle of a write: AW captured, W never arrives
        axi_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0);
        awaddr = 32'h10; awvalid = 1;
        tick;
        awvalid = 0;
        chk("mid_awrdy", awready, 0);
        rst = 1;
        tick;
        chk("mid_rst_awrdy", awready, 0);
        chk("mid_rst_wrdy", wready, 0);
        tick;
        rst = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("mid_no_bvalid", bvalid, 0);
        end
        axi_read(32'h10, 0, got);
        chk("mid_reg4_zero", got, 0);
        axi_read(32'h400, 0, got);
        axi_write(32'h18, 32'h0BADF00D, 4'hF, 1, 0);
        axi_read(32'h18, 0, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
